// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-side memory arbiters (this arbiter and the future L2 arbiter).
// Latency: n/a (types and a pure selection function only).
// Backpressure: n/a.
package cache_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int WD_W   = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [WD_W-1:0]   wd_cnt_t;

    // Arbiter FSM: one line transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    // Identity of a requester. Also used to remember the previous grant.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    // Winner selection for one arbitration slot.
    // A lone requester always wins. On a tie, D wins outright when d_priority
    // is set; otherwise the grant alternates away from last_grant. Because
    // last_grant resets to REQ_I, the first tie after reset goes to D.
    // The result is only meaningful when at least one request is pending.
    function automatic arb_req_t pick_winner(
        input logic     i_pend,
        input logic     d_pend,
        input logic     d_priority,
        input arb_req_t last_grant
    );
        arb_req_t w;
        if (i_pend && !d_pend) begin
            w = REQ_I;
        end else if (d_pend && !i_pend) begin
            w = REQ_D;
        end else if (d_priority) begin
            w = REQ_D;
        end else begin
            w = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// One line-granular memory port: a requester (master) asks for a 256-bit line read or write-back.
// Latency: request is a level held until the 1-cycle resp pulse; rdata valid only while resp is high.
// Backpressure: the responder simply delays resp; the requester holds address/read/write/wdata stable.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;

    addr_t address;
    logic  read;
    logic  write;
    line_t wdata;
    line_t rdata;
    logic  resp;

    // Requester side (a cache, or the arbiter toward the adaptor).
    modport master (
        output address,
        output read,
        output write,
        output wdata,
        input  rdata,
        input  resp
    );

    // Responder side (the arbiter toward a cache, or the adaptor).
    modport slave (
        input  address,
        input  read,
        input  write,
        input  wdata,
        output rdata,
        output resp
    );

endinterface

// File: rtl/cache_arbiter.sv
// Shares the single cacheline-adaptor port between the I-cache (read-only) and the D-cache (read/write-back).
// Latency: m_read/m_write rise 1 cycle after a request is first seen in IDLE; resp is forwarded combinationally.
// Backpressure: requesters hold their level request until resp; at most one transaction outstanding, idle gap between.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter logic          D_PRIORITY = 1'b0,
    parameter logic [WD_W-1:0] TIMEOUT  = 16'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    cache_arbiter_if.slave    icache,
    cache_arbiter_if.slave    dcache,
    cache_arbiter_if.master   mem,
    output logic              timeout_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t state;
    arb_req_t   last_grant;
    addr_t      m_address;
    logic       m_read;
    logic       m_write;
    line_t      m_wdata;
    wd_cnt_t    wd_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic     i_pend;
    logic     d_pend;
    logic     any_pend;
    arb_req_t winner;
    logic     d_op_write;
    wd_cnt_t  wd_next;
    logic     wd_hit;

    // The I-cache never writes; its write strobe and data lines exist only
    // because it shares the port type with the D-cache.
    logic unused_icache_wr;
    assign unused_icache_wr = ^{icache.write, icache.wdata};

    // Request decode, winner pick and watchdog next-count.
    always_comb begin
        i_pend     = icache.read;
        d_pend     = dcache.read | dcache.write;
        any_pend   = i_pend | d_pend;
        winner     = pick_winner(i_pend, d_pend, D_PRIORITY, last_grant);
        // read and write together is illegal; write wins so a dirty line is never lost
        d_op_write = dcache.write;
        wd_next    = (wd_cnt == {WD_W{1'b1}}) ? wd_cnt : wd_cnt + 1'b1;
        // timeout_err is set on the edge that brings wd_cnt to TIMEOUT, so it
        // rises in the same cycle the count reaches the limit
        wd_hit     = (TIMEOUT != '0) && (wd_next == TIMEOUT);
    end

    // ------------------------------------------------------------------
    // Downstream (adaptor) port: registered request, shared read data
    // ------------------------------------------------------------------
    assign mem.address = m_address;
    assign mem.read    = m_read;
    assign mem.write   = m_write;
    assign mem.wdata   = m_wdata;

    // Responses are steered to whichever cache owns the grant; a stray
    // resp while IDLE reaches neither cache.
    assign icache.resp  = (state == GRANT_I) && mem.resp;
    assign dcache.resp  = (state == GRANT_D) && mem.resp;
    assign icache.rdata = mem.rdata;
    assign dcache.rdata = mem.rdata;

    // Arbitration FSM, latched downstream request, round-robin history and watchdog.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= REQ_I;
            m_address   <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_wdata     <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (any_pend) begin
                        if (winner == REQ_D) begin
                            state     <= GRANT_D;
                            m_address <= dcache.address;
                            m_write   <= d_op_write;
                            m_read    <= ~d_op_write;
                            m_wdata   <= dcache.wdata;
                        end else begin
                            state     <= GRANT_I;
                            m_address <= icache.address;
                            m_write   <= 1'b0;
                            m_read    <= 1'b1;
                            m_wdata   <= '0;
                        end
                    end
                end

                GRANT_I, GRANT_D: begin
                    if (mem.resp) begin
                        // Completion: drop the request and always pass through
                        // IDLE, so new requests are only seen next cycle.
                        state      <= IDLE;
                        m_read     <= 1'b0;
                        m_write    <= 1'b0;
                        last_grant <= (state == GRANT_D) ? REQ_D : REQ_I;
                        wd_cnt     <= '0;
                    end else begin
                        // Watchdog only reports; the transaction is never aborted.
                        wd_cnt <= wd_next;
                        if (wd_hit) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    wd_cnt  <= '0;
                end
            endcase
        end
    end

    // Protocol checks on the cache and adaptor sides; simulation only.
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!((state == IDLE) && mem.resp))
                else $warning("cache_arbiter: adaptor resp while IDLE ignored");
            assert (!(dcache.read && dcache.write))
                else $error("cache_arbiter: dcache read and write both asserted");
            assert (!icache.write)
                else $error("cache_arbiter: icache write asserted");
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter (round-robin + watchdog instance, D-priority instance).
// Inputs are driven 2 time units after the rising edge; outputs are sampled before the next edge.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic terr0;
    logic terr1;

    always #5 clk = ~clk;

    cache_arbiter_if ic0 ();
    cache_arbiter_if dc0 ();
    cache_arbiter_if mm0 ();
    cache_arbiter_if ic1 ();
    cache_arbiter_if dc1 ();
    cache_arbiter_if mm1 ();

    cache_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT(16'd8)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .icache(ic0.slave), .dcache(dc0.slave), .mem(mm0.master),
        .timeout_err(terr0)
    );

    cache_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT(16'd0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .icache(ic1.slave), .dcache(dc1.slave), .mem(mm1.master),
        .timeout_err(terr1)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp)
            else begin
                n_fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b1;
        ic0.address = '0; ic0.read = 1'b0; ic0.write = 1'b0; ic0.wdata = '0;
        dc0.address = '0; dc0.read = 1'b0; dc0.write = 1'b0; dc0.wdata = '0;
        ic1.address = '0; ic1.read = 1'b0; ic1.write = 1'b0; ic1.wdata = '0;
        dc1.address = '0; dc1.read = 1'b0; dc1.write = 1'b0; dc1.wdata = '0;
        mm0.rdata = '0; mm0.resp = 1'b0;
        mm1.rdata = '0; mm1.resp = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) tick();

        // ---------------- reset state ----------------
        check("rst_m_read",   mm0.read,    0);
        check("rst_m_write",  mm0.write,   0);
        check("rst_m_addr",   mm0.address, 0);
        check("rst_m_wdata",  mm0.wdata,   0);
        check("rst_i_resp",   ic0.resp,    0);
        check("rst_d_resp",   dc0.resp,    0);
        check("rst_terr",     terr0,       0);
        check("rst_m_read_1", mm1.read,    0);
        reset_n = 1'b1;
        tick();

        // ---------------- 1: lone I-cache fill ----------------
        ic0.address = 32'h0000_1000; ic0.read = 1'b1; #1;
        check("t1_not_same_cycle", mm0.read, 0);
        tick();
        check("t1_m_read",  mm0.read,    1);
        check("t1_m_addr",  mm0.address, 32'h0000_1000);
        check("t1_m_write", mm0.write,   0);
        tick();
        mm0.rdata = {32{8'hA5}}; mm0.resp = 1'b1; #1;
        check("t1_i_resp",  ic0.resp,  1);
        check("t1_i_rdata", ic0.rdata, {32{8'hA5}});
        check("t1_d_resp",  dc0.resp,  0);
        tick();
        ic0.read = 1'b0; mm0.resp = 1'b0; #1;
        check("t1_m_read_drop", mm0.read, 0);
        check("t1_i_resp_pulse", ic0.resp, 0);

        // ---------------- 2: D write-back then D fill ----------------
        dc0.address = 32'h0000_2000; dc0.wdata = {8{32'h1234_5678}}; dc0.write = 1'b1;
        tick();
        check("t2_m_write", mm0.write,   1);
        check("t2_m_read",  mm0.read,    0);
        check("t2_m_addr",  mm0.address, 32'h0000_2000);
        check("t2_m_wdata", mm0.wdata,   {8{32'h1234_5678}});
        mm0.resp = 1'b1; #1;
        check("t2_wb_d_resp", dc0.resp, 1);
        check("t2_wb_i_resp", ic0.resp, 0);
        tick();
        dc0.write = 1'b0; mm0.resp = 1'b0;
        dc0.address = 32'h0000_3000; dc0.read = 1'b1; #1;
        check("t2_gap_write", mm0.write, 0);
        check("t2_gap_read",  mm0.read,  0);
        tick();
        check("t2_fill_read",  mm0.read,    1);
        check("t2_fill_write", mm0.write,   0);
        check("t2_fill_addr",  mm0.address, 32'h0000_3000);
        mm0.rdata = {16{16'hBEEF}}; mm0.resp = 1'b1; #1;
        check("t2_fill_d_resp",  dc0.resp,  1);
        check("t2_fill_d_rdata", dc0.rdata, {16{16'hBEEF}});
        tick();
        dc0.read = 1'b0; mm0.resp = 1'b0;

        // ---------------- 3a: round-robin tie from reset ----------------
        reset_n = 1'b0;
        ic0.address = 32'h0000_5000; ic0.read = 1'b1;
        dc0.address = 32'h0000_4000; dc0.read = 1'b1;
        #2 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t3_rr%0d_addr", k), mm0.address,
                  (k % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000);
            mm0.resp = 1'b1; #1;
            check($sformatf("t3_rr%0d_d_resp", k), dc0.resp, (k % 2 == 0));
            check($sformatf("t3_rr%0d_i_resp", k), ic0.resp, (k % 2 == 1));
            tick();
            mm0.resp = 1'b0; #1;
            check($sformatf("t3_rr%0d_gap", k), mm0.read, 0);
        end
        ic0.read = 1'b0; dc0.read = 1'b0;

        // ---------------- 3b: D priority starves I while D pending ----------------
        ic1.address = 32'h0000_8000; ic1.read = 1'b1;
        dc1.address = 32'h0000_9000; dc1.read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t3p_%0d_addr", k), mm1.address, 32'h0000_9000);
            mm1.resp = 1'b1; #1;
            check($sformatf("t3p_%0d_i_resp", k), ic1.resp, 0);
            tick();
            mm1.resp = 1'b0;
        end
        dc1.read = 1'b0;
        tick();
        check("t3p_i_addr", mm1.address, 32'h0000_8000);
        check("t3p_i_read", mm1.read,    1);
        mm1.resp = 1'b1; #1;
        check("t3p_i_resp", ic1.resp, 1);
        tick();
        ic1.read = 1'b0; mm1.resp = 1'b0;

        // ---------------- 4: async reset mid GRANT_D ----------------
        dc0.address = 32'h0000_6000; dc0.wdata = {8{32'hCAFE_F00D}}; dc0.write = 1'b1;
        tick();
        check("t4_pre_write", mm0.write, 1);
        mm0.resp = 1'b1; reset_n = 1'b0; #1;
        check("t4_rst_write",  mm0.write,   0);
        check("t4_rst_read",   mm0.read,    0);
        check("t4_rst_addr",   mm0.address, 0);
        check("t4_rst_wdata",  mm0.wdata,   0);
        check("t4_rst_d_resp", dc0.resp,    0);
        mm0.resp = 1'b0; #1;
        reset_n = 1'b1;
        tick();
        check("t4_rearb_write", mm0.write,   1);
        check("t4_rearb_addr",  mm0.address, 32'h0000_6000);
        mm0.resp = 1'b1; #1;
        check("t4_rearb_d_resp", dc0.resp, 1);
        tick();
        dc0.write = 1'b0; mm0.resp = 1'b0;

        // ---------------- 5: watchdog, adaptor stalls ----------------
        check("t5_terr_before", terr0, 0);
        ic0.address = 32'h0000_7000; ic0.read = 1'b1;
        tick();
        check("t5_m_read", mm0.read, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t5_terr_c%0d", k), terr0, (k == 8));
        end
        mm0.resp = 1'b1; #1;
        check("t5_late_i_resp", ic0.resp, 1);
        tick();
        ic0.read = 1'b0; mm0.resp = 1'b0;
        tick();
        check("t5_terr_sticky", terr0, 1);
        reset_n = 1'b0; #1;
        check("t5_terr_rst", terr0, 0);
        #1 reset_n = 1'b1;
        tick();

        // ---------------- 6: stray adaptor resp while IDLE ----------------
        mm0.rdata = {32{8'h5A}}; mm0.resp = 1'b1; #1;
        check("t6_i_resp", ic0.resp, 0);
        check("t6_d_resp", dc0.resp, 0);
        tick();
        mm0.resp = 1'b0; #1;
        check("t6_m_read",  mm0.read,  0);
        check("t6_m_write", mm0.write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
